// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types and encodings for the CPU controller slice:
//               control-FSM state enum, opcode/op field values, ALU_op,
//               shift and write-back select codes.
//               ILLEGAL_TRAP_EN adds the HALT state used for undefined
//               opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Control FSM states. HALT exists only when undefined instructions trap.
  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_GET_A     = 3'd2,
    S_GET_B     = 3'd3,
    S_COMPUTE   = 3'd4,
    S_WRITE_REG = 3'd5,
    S_WRITE_IMM = 3'd6
`ifdef ILLEGAL_TRAP_EN
    ,S_HALT     = 3'd7
`endif
  } state_t;

  // opcode field IR[15:13]
  localparam logic [2:0] c_OPC_MOV = 3'b110;
  localparam logic [2:0] c_OPC_ALU = 3'b101;

  // op field IR[12:11]
  localparam logic [1:0] c_OP_MOV_REG = 2'b00;
  localparam logic [1:0] c_OP_MOV_IMM = 2'b10;
  localparam logic [1:0] c_OP_ADD     = 2'b00;
  localparam logic [1:0] c_OP_CMP     = 2'b01;
  localparam logic [1:0] c_OP_AND     = 2'b10;
  localparam logic [1:0] c_OP_MVN     = 2'b11;

  // ALU_op codes
  localparam logic [1:0] c_ALU_ADD = 2'b00;
  localparam logic [1:0] c_ALU_SUB = 2'b01;
  localparam logic [1:0] c_ALU_AND = 2'b10;
  localparam logic [1:0] c_ALU_NOT = 2'b11;

  // shifter codes
  localparam logic [1:0] c_SH_NONE = 2'b00;
  localparam logic [1:0] c_SH_LSL  = 2'b01;
  localparam logic [1:0] c_SH_LSR  = 2'b10;
  localparam logic [1:0] c_SH_ASR  = 2'b11;

  // write-back mux select
  localparam logic [1:0] c_WB_C     = 2'b00;
  localparam logic [1:0] c_WB_PC    = 2'b01;
  localparam logic [1:0] c_WB_IMM8  = 2'b10;
  localparam logic [1:0] c_WB_MDATA = 2'b11;

endpackage
`default_nettype wire

// File: rtl/cpu_idecoder.sv
`default_nettype none
// ============================================================================
// Module      : cpu_idecoder
// Description : Combinational instruction field extraction and immediate
//               sign extension from the instruction register.
// Ports       : i_ir       in  16  instruction register contents
//               o_opcode   out 3   IR[15:13]
//               o_op       out 2   IR[12:11]
//               o_rn       out 3   IR[10:8]
//               o_rd       out 3   IR[7:5]
//               o_sh       out 2   IR[4:3]
//               o_rm       out 3   IR[2:0]
//               o_sximm8   out 16  sign-extended IR[7:0]
//               o_sximm5   out 16  sign-extended IR[4:0]
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_idecoder
  import cpu_pkg::*;
(
  input  logic [15:0] i_ir,
  output logic [2:0]  o_opcode,
  output logic [1:0]  o_op,
  output logic [2:0]  o_rn,
  output logic [2:0]  o_rd,
  output logic [1:0]  o_sh,
  output logic [2:0]  o_rm,
  output logic [15:0] o_sximm8,
  output logic [15:0] o_sximm5
);

  assign o_opcode = i_ir[15:13];
  assign o_op     = i_ir[12:11];
  assign o_rn     = i_ir[10:8];
  assign o_rd     = i_ir[7:5];
  assign o_sh     = i_ir[4:3];
  assign o_rm     = i_ir[2:0];

  assign o_sximm8 = {{8{i_ir[7]}}, i_ir[7:0]};
  assign o_sximm5 = {{11{i_ir[4]}}, i_ir[4:0]};

endmodule
`default_nettype wire

// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
// Module      : cpu_controller
// Description : Instruction register, decoder and control FSM feeding the
//               datapath. One 16-bit instruction is captured per accepted
//               start and sequenced over several clocks (Moore outputs).
//               Optional build macro ILLEGAL_TRAP_EN: undefined opcodes park
//               the FSM in HALT and raise 'illegal' until reset; without it
//               they are executed as NOPs and the 'illegal' port is absent.
// Ports       : clk, rst (sync, active-high)
//               start, instr_in         instruction request / word
//               waiting                 idle, ready for start
//               r_addr, w_addr, w_en    register-file access
//               wb_sel                  write-back mux select
//               en_A/en_B/en_C/en_status  datapath register loads
//               shift_op, sel_A, sel_B, ALU_op  datapath operation controls
//               sximm8, sximm5          sign-extended immediates
//               illegal                 trap flag (ILLEGAL_TRAP_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_controller
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] instr_in,
  output logic        waiting,
  output logic [2:0]  r_addr,
  output logic [2:0]  w_addr,
  output logic        w_en,
  output logic [1:0]  wb_sel,
  output logic        en_A,
  output logic        en_B,
  output logic        en_C,
  output logic        en_status,
  output logic [1:0]  shift_op,
  output logic        sel_A,
  output logic        sel_B,
  output logic [1:0]  ALU_op,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
`ifdef ILLEGAL_TRAP_EN
  ,output logic       illegal
`endif
);

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_ir;

  logic [2:0]  w_opcode;
  logic [1:0]  w_op;
  logic [2:0]  w_rn;
  logic [2:0]  w_rd;
  logic [1:0]  w_sh;
  logic [2:0]  w_rm;

  logic        w_is_mov_imm;
  logic        w_is_mov_reg;
  logic        w_is_mvn;
  logic        w_is_two_src;
  logic        w_is_cmp;

  cpu_idecoder u_idecoder (
    .i_ir     (r_ir),
    .o_opcode (w_opcode),
    .o_op     (w_op),
    .o_rn     (w_rn),
    .o_rd     (w_rd),
    .o_sh     (w_sh),
    .o_rm     (w_rm),
    .o_sximm8 (sximm8),
    .o_sximm5 (sximm5)
  );

  // Instruction classes. ADD/CMP/AND read Rn into A; MOV reg and MVN only
  // need Rm, so they skip GET_A.
  assign w_is_mov_imm = (w_opcode == c_OPC_MOV) && (w_op == c_OP_MOV_IMM);
  assign w_is_mov_reg = (w_opcode == c_OPC_MOV) && (w_op == c_OP_MOV_REG);
  assign w_is_mvn     = (w_opcode == c_OPC_ALU) && (w_op == c_OP_MVN);
  assign w_is_two_src = (w_opcode == c_OPC_ALU) && (w_op != c_OP_MVN);
  assign w_is_cmp     = (w_opcode == c_OPC_ALU) && (w_op == c_OP_CMP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_WAIT;
      r_ir    <= 16'h0000;
    end else begin
      r_state <= w_next_state;
      if ((r_state == S_WAIT) && start) begin
        r_ir <= instr_in;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    waiting      = 1'b0;
    r_addr       = 3'd0;
    w_addr       = 3'd0;
    w_en         = 1'b0;
    wb_sel       = c_WB_C;
    en_A         = 1'b0;
    en_B         = 1'b0;
    en_C         = 1'b0;
    en_status    = 1'b0;
    shift_op     = w_sh;
    sel_A        = 1'b0;
    sel_B        = 1'b0;
    ALU_op       = w_op;
`ifdef ILLEGAL_TRAP_EN
    illegal      = 1'b0;
`endif

    case (r_state)
      S_WAIT: begin
        waiting = 1'b1;
        if (start) begin
          w_next_state = S_DECODE;
        end
      end

      S_DECODE: begin
        if (w_is_mov_imm) begin
          w_next_state = S_WRITE_IMM;
        end else if (w_is_mov_reg || w_is_mvn) begin
          w_next_state = S_GET_B;
        end else if (w_is_two_src) begin
          w_next_state = S_GET_A;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          w_next_state = S_HALT;
`else
          w_next_state = S_WAIT;
`endif
        end
      end

      S_GET_A: begin
        r_addr       = w_rn;
        en_A         = 1'b1;
        w_next_state = S_GET_B;
      end

      S_GET_B: begin
        r_addr       = w_rm;
        en_B         = 1'b1;
        w_next_state = S_COMPUTE;
      end

      S_COMPUTE: begin
        en_C = 1'b1;
        // MOV reg is computed as 0 + shifted Rm.
        if (w_is_mov_reg) begin
          sel_A  = 1'b1;
          ALU_op = c_ALU_ADD;
        end
        // CMP only updates flags; nothing is written back.
        if (w_is_cmp) begin
          en_status    = 1'b1;
          w_next_state = S_WAIT;
        end else begin
          w_next_state = S_WRITE_REG;
        end
      end

      S_WRITE_REG: begin
        wb_sel       = c_WB_C;
        w_addr       = w_rd;
        w_en         = 1'b1;
        w_next_state = S_WAIT;
      end

      S_WRITE_IMM: begin
        wb_sel       = c_WB_IMM8;
        w_addr       = w_rn;
        w_en         = 1'b1;
        w_next_state = S_WAIT;
      end

`ifdef ILLEGAL_TRAP_EN
      S_HALT: begin
        illegal      = 1'b1;
        w_next_state = S_HALT;
      end
`endif

      default: begin
        w_next_state = S_WAIT;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_controller
// Description : Directed self-checking bench for cpu_controller. Walks each
//               instruction class state by state and compares the Moore
//               outputs against hand-derived values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_controller;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] instr_in;
  logic        waiting;
  logic [2:0]  r_addr;
  logic [2:0]  w_addr;
  logic        w_en;
  logic [1:0]  wb_sel;
  logic        en_A;
  logic        en_B;
  logic        en_C;
  logic        en_status;
  logic [1:0]  shift_op;
  logic        sel_A;
  logic        sel_B;
  logic [1:0]  ALU_op;
  logic [15:0] sximm8;
  logic [15:0] sximm5;
`ifdef ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  int checks;
  int errors;

  cpu_controller dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .instr_in  (instr_in),
    .waiting   (waiting),
    .r_addr    (r_addr),
    .w_addr    (w_addr),
    .w_en      (w_en),
    .wb_sel    (wb_sel),
    .en_A      (en_A),
    .en_B      (en_B),
    .en_C      (en_C),
    .en_status (en_status),
    .shift_op  (shift_op),
    .sel_A     (sel_A),
    .sel_B     (sel_B),
    .ALU_op    (ALU_op),
    .sximm8    (sximm8),
    .sximm5    (sximm5)
`ifdef ILLEGAL_TRAP_EN
    ,.illegal  (illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle away from it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All five datapath/register-file enables packed for compact checks.
  function automatic logic [15:0] enables();
    return {11'd0, w_en, en_A, en_B, en_C, en_status};
  endfunction

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    instr_in = 16'h0000;

    // T1 reset
    tick();
    rst = 1'b0;
    check("T1 waiting", {15'd0, waiting}, 16'd1);
    check("T1 enables", enables(), 16'd0);
`ifdef ILLEGAL_TRAP_EN
    check("T1 illegal", {15'd0, illegal}, 16'd0);
`endif

    // T2 MOV R2,#-3
    instr_in = 16'hD2FD;
    start    = 1'b1;
    tick();                       // DECODE
    start    = 1'b0;
    check("T2 decode waiting", {15'd0, waiting}, 16'd0);
    check("T2 decode enables", enables(), 16'd0);
    tick();                       // WRITE_IMM
    check("T2 w_en",   {15'd0, w_en}, 16'd1);
    check("T2 w_addr", {13'd0, w_addr}, 16'd2);
    check("T2 wb_sel", {14'd0, wb_sel}, 16'd2);
    check("T2 sximm8", sximm8, 16'hFFFD);
    check("T2 sximm5", sximm5, 16'hFFFD);
    tick();
    check("T2 back to wait", {15'd0, waiting}, 16'd1);

    // T3 ADD R5,R2,R3,LSL#1
    instr_in = 16'hA2AB;
    start    = 1'b1;
    tick();                       // DECODE
    start    = 1'b0;
    tick();                       // GET_A
    check("T3 geta r_addr", {13'd0, r_addr}, 16'd2);
    check("T3 geta enables", enables(), 16'b01000);
    tick();                       // GET_B
    check("T3 getb r_addr", {13'd0, r_addr}, 16'd3);
    check("T3 getb enables", enables(), 16'b00100);
    tick();                       // COMPUTE
    check("T3 shift_op", {14'd0, shift_op}, 16'd1);
    check("T3 ALU_op", {14'd0, ALU_op}, 16'd0);
    check("T3 compute enables", enables(), 16'b00010);
    check("T3 sel_A", {15'd0, sel_A}, 16'd0);
    check("T3 sel_B", {15'd0, sel_B}, 16'd0);
    tick();                       // WRITE_REG
    check("T3 w_addr", {13'd0, w_addr}, 16'd5);
    check("T3 wb_sel", {14'd0, wb_sel}, 16'd0);
    check("T3 w_en", {15'd0, w_en}, 16'd1);
    tick();
    check("T3 back to wait", {15'd0, waiting}, 16'd1);

    // T4 CMP R4,R1
    instr_in = 16'hAC01;
    start    = 1'b1;
    tick();                       // DECODE
    start    = 1'b0;
    check("T4 c1 w_en", {15'd0, w_en}, 16'd0);
    tick();                       // GET_A
    check("T4 c2 r_addr", {13'd0, r_addr}, 16'd4);
    check("T4 c2 w_en", {15'd0, w_en}, 16'd0);
    tick();                       // GET_B
    check("T4 c3 r_addr", {13'd0, r_addr}, 16'd1);
    check("T4 c3 w_en", {15'd0, w_en}, 16'd0);
    tick();                       // COMPUTE
    check("T4 ALU_op", {14'd0, ALU_op}, 16'd1);
    check("T4 compute enables", enables(), 16'b00011);
    check("T4 c4 waiting", {15'd0, waiting}, 16'd0);
    tick();
    check("T4 waiting after 4", {15'd0, waiting}, 16'd1);
    check("T4 c5 w_en", {15'd0, w_en}, 16'd0);

    // T5 MVN R7,R0,ASR with start held high throughout
    instr_in = 16'hB8F8;
    start    = 1'b1;
    tick();                       // DECODE
    check("T5 decode en_A", {15'd0, en_A}, 16'd0);
    tick();                       // GET_B
    check("T5 getb enables", enables(), 16'b00100);
    check("T5 getb r_addr", {13'd0, r_addr}, 16'd0);
    tick();                       // COMPUTE
    check("T5 shift_op", {14'd0, shift_op}, 16'd3);
    check("T5 ALU_op", {14'd0, ALU_op}, 16'd3);
    check("T5 compute enables", enables(), 16'b00010);
    tick();                       // WRITE_REG
    check("T5 w_addr", {13'd0, w_addr}, 16'd7);
    check("T5 w_en", {15'd0, w_en}, 16'd1);
    tick();                       // WAIT (start still high)
    check("T5 wait after 4", {15'd0, waiting}, 16'd1);
    tick();                       // re-accepted -> DECODE
    start = 1'b0;
    check("T5 reentry", {15'd0, waiting}, 16'd0);
    tick(); tick(); tick(); tick();
    check("T5 second pass done", {15'd0, waiting}, 16'd1);

    // MOV R1,R6 : A input forced to zero, ALU adds
    instr_in = 16'hC026;
    start    = 1'b1;
    tick();                       // DECODE
    start    = 1'b0;
    tick();                       // GET_B
    check("MOVR getb r_addr", {13'd0, r_addr}, 16'd6);
    tick();                       // COMPUTE
    check("MOVR sel_A", {15'd0, sel_A}, 16'd1);
    check("MOVR ALU_op", {14'd0, ALU_op}, 16'd0);
    tick();                       // WRITE_REG
    check("MOVR w_addr", {13'd0, w_addr}, 16'd1);
    tick();
    check("MOVR back to wait", {15'd0, waiting}, 16'd1);

    // AND R3,R1,R2 : five-cycle latency, ALU_op 10
    instr_in = 16'hB162;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    tick(); tick(); tick();       // GET_A, GET_B, COMPUTE
    check("AND ALU_op", {14'd0, ALU_op}, 16'd2);
    check("AND compute en_status", {15'd0, en_status}, 16'd0);
    tick();                       // WRITE_REG
    check("AND w_addr", {13'd0, w_addr}, 16'd3);
    check("AND not waiting at 4", {15'd0, waiting}, 16'd0);
    tick();
    check("AND waiting at 5", {15'd0, waiting}, 16'd1);

    // T6 reset during GET_B abandons the ADD
    instr_in = 16'hA2AB;
    start    = 1'b1;
    tick();                       // DECODE
    start    = 1'b0;
    tick();                       // GET_A
    tick();                       // GET_B
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("T6 reset waiting", {15'd0, waiting}, 16'd1);
    check("T6 reset enables", enables(), 16'd0);
    tick();
    check("T6 still idle", {15'd0, waiting}, 16'd1);
    check("T6 no w_en", {15'd0, w_en}, 16'd0);

    // Undefined instruction 16'h0000
    instr_in = 16'h0000;
    start    = 1'b1;
    tick();                       // DECODE
    start    = 1'b0;
    tick();
`ifdef ILLEGAL_TRAP_EN
    check("T6 halt illegal", {15'd0, illegal}, 16'd1);
    check("T6 halt waiting", {15'd0, waiting}, 16'd0);
    check("T6 halt enables", enables(), 16'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("T6 halt sticky", {15'd0, illegal}, 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("T6 rst clears illegal", {15'd0, illegal}, 16'd0);
    check("T6 rst waiting", {15'd0, waiting}, 16'd1);
`else
    check("T6 nop waiting", {15'd0, waiting}, 16'd1);
    check("T6 nop enables", enables(), 16'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
